hilo_ctrl: RTL and testbench
============================

// Module: hilo_ctrl
// PURPOSE
// - Control-unit-side sequencer for the iterative mult/div engine: accepts a mult/div request,
//   clears the engine, drives its 2-bit control for the required cycle count, and captures the
//   engine Hi/Lo into the architectural HI/LO registers.
// - Also serves mthi/mtlo writes and reports divide-by-zero to the exception logic.
// PARAMETERS
// - MULT_CYCLES  32  RUN cycles with md_ctrl=OP_MULT before engine Hi/Lo are valid
// - DIV_CYCLES   33  RUN cycles with md_ctrl=OP_DIV before engine Hi/Lo are valid
// PORTS
// - clk           in   1   single clock; all state updates on posedge
// - reset         in   1   synchronous, active-low reset
// - op_start      in   1   request pulse; sampled only in IDLE
// - op_sel        in   2   1=mult, 2=div; 0/3 illegal
// - op_busy       out  1   high from the cycle after accepted start through CAPTURE
// - op_done       out  1   one-cycle pulse in CAPTURE
// - div_zero_exc  out  1   one-cycle pulse on divide-by-zero abort
// - md_clr        out  1   active-high clear to engine, one cycle in CLEAR
// - md_ctrl       out  2   engine control; equals latched op in RUN, else 0
// - md_hi, md_lo  in   32  engine results
// - md_divzero    in   1   engine divide-by-zero flag
// - wr_hi, wr_lo  in   1   mthi/mtlo write enables
// - wr_data       in   32  mthi/mtlo data
// - hi, lo        out  32  architectural HI/LO
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE, hi=lo=0, counter=0, every control output 0. Mid-op reset
//   aborts; no done/exception pulse.
// - FSM: IDLE -> CLEAR -> RUN -> CAPTURE -> IDLE.
//   IDLE: op_start & op_sel in {1,2} -> latch op, go CLEAR. Illegal op_sel: ignored, stay IDLE.
//   CLEAR: md_clr=1, md_ctrl=0, counter=0; next RUN.
//   RUN: md_ctrl=op; counter +1/cycle; leave after MULT_CYCLES or DIV_CYCLES cycles -> CAPTURE.
//   CAPTURE: hi<=md_hi, lo<=md_lo, op_done=1; next IDLE.
// - Latency: start at cycle 0 -> done at cycle 2+N (N=MULT_CYCLES/DIV_CYCLES); hi/lo registered at
//   end of done cycle.
// - Div-by-zero: md_divzero==1 in any RUN cycle with op=div -> div_zero_exc pulse same cycle,
//   md_ctrl=0 next cycle, go IDLE; hi/lo unchanged; no op_done. Ignored for mult.
// - op_start while busy: ignored, no queueing.
// - wr_hi/wr_lo: accepted in any state, take effect at posedge. In CAPTURE the engine capture wins.
// - Counter 6 bits; it never wraps: exit compare is exact equality.
// CONFIGURATION
// - HILO_BYPASS_EN defined: in CAPTURE, hi/lo outputs forward md_hi/md_lo combinationally. A consumer
//   reads results in the done cycle.
// - Not defined: hi/lo are pure register outputs; results are visible the cycle after op_done.
// STRUCTURE
// - Package hilo_pkg: state enum {IDLE,CLEAR,RUN,CAPTURE}; OP_MULT=2'd1, OP_DIV=2'd2;
//   MULT_CYCLES/DIV_CYCLES defaults.
// - One sub-module: hilo_cycle_cnt. It is a loadable 6-bit up-counter with clear and a terminal-count
//   compare against a selected limit.
// - FSM and HI/LO registers stay in hilo_ctrl.
// TESTING (bench models engine: Hi/Lo valid after N RUN cycles, divzero when B==0)
// - mult 7 * -3: start@0 -> md_clr@1, md_ctrl=1 cycles 2..33, op_done@34; next cycle hi=32'hFFFFFFFF,
//   lo=32'hFFFFFFEB.
// - div 100 / 7: md_ctrl=2 for 33 cycles, op_done@35; next cycle lo=14, hi=2.
// - div by 0: md_divzero high on 2nd RUN cycle -> div_zero_exc one pulse, no op_done, busy low next
//   cycle; hi/lo keep prior 14/2.
// - mthi 32'hDEADBEEF in IDLE -> hi=DEADBEEF next cycle. wr_lo during CAPTURE of a mult -> lo=engine
//   value, not wr_data.
// - reset low at RUN cycle 10 -> next cycle IDLE, hi=lo=0, md_ctrl=0, no pulses. op_start in RUN is
//   ignored. op_sel=3 in IDLE is ignored.
// - Rebuild with HILO_BYPASS_EN: mult 7 * -3 shows lo=FFFFFFEB on the hi/lo outputs in the op_done
//   cycle itself.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO mult/div sequencer.
package hilo_pkg;

  // Width of the RUN-phase cycle counter; must hold the longest limit.
  localparam int CNT_W = 6;

  // Engine latencies: RUN cycles before engine Hi/Lo are valid.
  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 33;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Engine control encoding; also the legal op_sel values.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MULT = 2'd1,
    OP_DIV  = 2'd2
  } op_t;

  // Only mult and div start the engine; 0 and 3 are dropped.
  function automatic logic is_legal_op(input logic [1:0] sel);
    return (sel == OP_MULT) || (sel == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_cycle_cnt.sv
// Loadable up-counter with clear and a terminal-count compare, used to
// time the RUN phase of the mult/div engine.
module hilo_cycle_cnt
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop sees pre-edge values.
    if (!reset || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Exact-equality compare: the owner stops counting here, so no wrap is possible.
  assign tc = (cnt == limit);

endmodule

// File: rtl/hilo_ctrl.sv
// Sequencer between the control unit and the iterative mult/div engine.
// Clears the engine, drives its control for the required cycle count,
// captures engine Hi/Lo into HI/LO, serves mthi/mtlo and aborts on divide
// by zero.
// Build option HILO_BYPASS_EN: when defined, hi/lo forward the engine
// results combinationally during CAPTURE so they are readable in the
// op_done cycle; otherwise hi/lo are pure register outputs.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  output logic        op_busy,
  output logic        op_done,
  output logic        div_zero_exc,
  output logic        md_clr,
  output logic [1:0]  md_ctrl,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_divzero,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter runs 0..N-1 across the N RUN cycles, so the terminal value is N-1.
  localparam logic [CNT_W-1:0] MULT_LIM = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LIM  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  op_t              op_q;
  logic [31:0]      hi_q, lo_q;
  logic             cnt_clr, cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_limit;

  assign cnt_limit = (op_q == OP_DIV) ? DIV_LIM : MULT_LIM;

  hilo_cycle_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .limit    (cnt_limit),
    .tc       (cnt_tc)
  );

  // State register and the op latched when a request is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OP_NONE;
    end else begin
      state <= state_nxt;
      if (state == IDLE && op_start && is_legal_op(op_sel)) begin
        op_q <= op_t'(op_sel);
      end
    end
  end

  // Next-state and engine-side controls, all decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt    = state;
    md_clr       = 1'b0;
    md_ctrl      = OP_NONE;
    op_done      = 1'b0;
    div_zero_exc = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_start && is_legal_op(op_sel)) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        md_clr    = 1'b1;
        cnt_load  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        md_ctrl = op_q;
        if (op_q == OP_DIV && md_divzero) begin
          // Abort: flag the exception now, drop the engine next cycle.
          div_zero_exc = 1'b1;
          cnt_clr      = 1'b1;
          state_nxt    = IDLE;
        end else if (cnt_tc) begin
          cnt_clr   = 1'b1;
          state_nxt = CAPTURE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      CAPTURE: begin
        op_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign op_busy = (state != IDLE);

  // HI/LO registers: engine capture has priority over mthi/mtlo in CAPTURE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == CAPTURE) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else begin
      if (wr_hi) hi_q <= wr_data;
      if (wr_lo) lo_q <= wr_data;
    end
  end

`ifdef HILO_BYPASS_EN
  assign hi = (state == CAPTURE) ? md_hi : hi_q;
  assign lo = (state == CAPTURE) ? md_lo : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl. Models the engine (results valid after
// N RUN cycles, divide-by-zero flag when the divisor is 0) and predicts
// every control output from the cycle offset since the accepted start.
module tb_hilo_ctrl;

  localparam int MULT_N = 32;
  localparam int DIV_N  = 33;
  localparam logic [1:0] SEL_MULT = 2'd1;
  localparam logic [1:0] SEL_DIV  = 2'd2;
`ifdef HILO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start;
  logic [1:0]  op_sel;
  logic        op_busy, op_done, div_zero_exc, md_clr;
  logic [1:0]  md_ctrl;
  logic [31:0] md_hi, md_lo;
  logic        md_divzero;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi, lo;

  logic [5:0]  ctl;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_hi, exp_lo;

  assign ctl = {op_busy, op_done, div_zero_exc, md_clr, md_ctrl};

  hilo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_sel       (op_sel),
    .op_busy      (op_busy),
    .op_done      (op_done),
    .div_zero_exc (div_zero_exc),
    .md_clr       (md_clr),
    .md_ctrl      (md_ctrl),
    .md_hi        (md_hi),
    .md_lo        (md_lo),
    .md_divzero   (md_divzero),
    .wr_hi        (wr_hi),
    .wr_lo        (wr_lo),
    .wr_data      (wr_data),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs;
    op_start   = 1'b0;
    op_sel     = 2'd0;
    md_divzero = 1'b0;
    md_hi      = $urandom;
    md_lo      = $urandom;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    wr_data    = '0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // One whole operation, cycle by cycle. Offset p counts from the start cycle:
  // p=1 CLEAR, p=2..N+1 RUN, p=N+2 CAPTURE.
  task automatic do_op(input string name, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit start_noise, input bit wr_noise, input bit cap_wr);
    int          n;
    longint      sa, sb;
    logic [63:0] res;
    logic [5:0]  exp_ctl;
    logic [31:0] vis_hi, vis_lo;
    bit          run, cap, abort;
    n   = (sel == SEL_MULT) ? MULT_N : DIV_N;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    if (sel == SEL_MULT) res = 64'(sa * sb);
    else if (b != 0) res = {32'(sa % sb), 32'(sa / sb)};
    abort = 1'b0;
    for (int p = 0; p <= n + 2 && !abort; p++) begin
      run        = (p >= 2) && (p <= n + 1);
      cap        = (p == n + 2);
      op_start   = (p == 0) || (start_noise && run);
      op_sel     = (p == 0) ? sel : 2'($urandom_range(0, 3));
      md_divzero = run && (b == 0) && (p == 3);
      md_hi      = cap ? res[63:32] : $urandom;
      md_lo      = cap ? res[31:0]  : $urandom;
      wr_hi      = (cap && cap_wr) || (wr_noise && $urandom_range(0, 3) == 0);
      wr_lo      = (cap && cap_wr) || (wr_noise && $urandom_range(0, 3) == 0);
      wr_data    = (cap && cap_wr) ? 32'h1234_5678 : $urandom;
      #1;
      exp_ctl = {p >= 1, cap, run && sel == SEL_DIV && md_divzero, p == 1,
                 run ? sel : 2'd0};
      vis_hi  = (BYPASS && cap) ? res[63:32] : exp_hi;
      vis_lo  = (BYPASS && cap) ? res[31:0]  : exp_lo;
      checks++;
      if (ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl p=%0d: got %b expected %b (busy,done,exc,clr,ctrl)",
                 name, p, ctl, exp_ctl);
      end
      checks++;
      if ({hi, lo} !== {vis_hi, vis_lo}) begin
        errors++;
        $display("FAIL %s hilo p=%0d: got %h_%h expected %h_%h",
                 name, p, hi, lo, vis_hi, vis_lo);
      end
      abort = exp_ctl[3];
      @(posedge clk);
      if (cap) begin
        exp_hi = res[63:32];
        exp_lo = res[31:0];
      end else begin
        if (wr_hi) exp_hi = wr_data;
        if (wr_lo) exp_lo = wr_data;
      end
      #1;
    end
    idle_inputs;
    #1;
    checks++;
    if (ctl !== 6'b0) begin
      errors++;
      $display("FAIL %s after: ctl got %b expected 000000", name, ctl);
    end
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++;
      $display("FAIL %s after: hilo got %h_%h expected %h_%h", name, hi, lo, exp_hi, exp_lo);
    end
    next_cycle;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs;
    wr_hi   = 1'b1;
    wr_data = 32'hFFFF_FFFF;
    repeat (2) next_cycle;
    checks++;
    if ({ctl, hi, lo} !== {6'b0, 64'b0}) begin
      errors++;
      $display("FAIL reset: ctl=%b hi=%h lo=%h expected all zero", ctl, hi, lo);
    end
    reset = 1'b1;
    idle_inputs;
    next_cycle;
    checks++;
    if (ctl !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: ctl got %b expected 000000", ctl);
    end
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic test_mthi_mtlo;
    wr_hi   = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    next_cycle;
    wr_hi   = 1'b0;
    wr_lo   = 1'b1;
    wr_data = 32'h0BAD_F00D;
    #1;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h expected DEADBEEF 00000000", hi, lo);
    end
    next_cycle;
    idle_inputs;
    #1;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h expected DEADBEEF 0BADF00D", hi, lo);
    end
    exp_hi = 32'hDEAD_BEEF;
    exp_lo = 32'h0BAD_F00D;
  endtask

  task automatic test_illegal_sel;
    logic [1:0] bad [2];
    bad[0] = 2'd3;
    bad[1] = 2'd0;
    for (int i = 0; i < 2; i++) begin
      op_start = 1'b1;
      op_sel   = bad[i];
      next_cycle;
      idle_inputs;
      #1;
      checks++;
      if (ctl !== 6'b0) begin
        errors++;
        $display("FAIL illegal_sel %0d: ctl got %b expected 000000", bad[i], ctl);
      end
    end
  endtask

  task automatic test_mult;
    do_op("mult_7x-3", SEL_MULT, 32'd7, -32'sd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h expected FFFFFFFF FFFFFFEB", hi, lo);
    end
  endtask

  task automatic test_div;
    do_op("div_100/7", SEL_DIV, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL div_result: hi=%0d lo=%0d expected 2 14", hi, lo);
    end
  endtask

  task automatic test_div_zero;
    do_op("div_by_0", SEL_DIV, 32'd55, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL divzero_keep: hi=%0d lo=%0d expected 2 14", hi, lo);
    end
  endtask

  task automatic test_mult_zero;
    // Divide-by-zero flag raised during a mult must be ignored.
    do_op("mult_by_0", SEL_MULT, 32'd1234, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_capture_write;
    do_op("cap_write", SEL_MULT, 32'd5, 32'd9, 1'b0, 1'b0, 1'b1);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd45) begin
      errors++;
      $display("FAIL cap_write_result: hi=%h lo=%h expected 00000000 0000002d", hi, lo);
    end
  endtask

  task automatic test_start_while_busy;
    do_op("busy_start", SEL_DIV, -32'sd1000, 32'd33, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    op_start = 1'b1;
    op_sel   = SEL_MULT;
    next_cycle;
    op_start = 1'b0;
    repeat (11) next_cycle;
    // Now in the 11th RUN cycle (counter value 10).
    checks++;
    if (ctl !== {4'b1000, SEL_MULT}) begin
      errors++;
      $display("FAIL reset_mid_pre: ctl got %b expected 100001", ctl);
    end
    reset = 1'b0;
    next_cycle;
    reset = 1'b1;
    #1;
    checks++;
    if ({ctl, hi, lo} !== {6'b0, 64'b0}) begin
      errors++;
      $display("FAIL reset_mid: ctl=%b hi=%h lo=%h expected all zero", ctl, hi, lo);
    end
    exp_hi = '0;
    exp_lo = '0;
    for (int i = 0; i < 30; i++) begin
      next_cycle;
      checks++;
      if (ctl !== 6'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc=%0d: ctl got %b expected 000000", i, ctl);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  sel;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      sel = ($urandom_range(0, 1) == 0) ? SEL_MULT : SEL_DIV;
      a   = $urandom;
      b   = (sel == SEL_MULT) ? $urandom : 32'($urandom_range(2, 5000));
      if ($urandom_range(0, 1) == 1) b = -b;
      do_op($sformatf("rand%0d", i), sel, a, b, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_illegal_sel;
    test_mult;
    test_div;
    test_div_zero;
    test_mult_zero;
    test_capture_write;
    test_start_while_busy;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
